// File: rtl/run_len_detector.sv
// Moore run-length detector with saturating run and hit-event counters.
// Define RUN_LEN_DETECTOR_MAXRUN_EN to track the longest run seen.
module run_len_detector #(
    parameter int CNT_W = 4,
    parameter int DET_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             x_in,
    input  logic             match_val,
    input  logic [CNT_W-1:0] thresh,
    output logic             y_out,
    output logic             y_pulse,
    output logic [CNT_W-1:0] run_cnt,
    output logic [DET_W-1:0] det_cnt,
    output logic [CNT_W-1:0] max_run
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HIT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] run_nx;
    logic [DET_W-1:0] det_nx;
    logic             pulse_nx;
    logic [CNT_W-1:0] eff_thresh;
    logic [CNT_W-1:0] run_inc;
    logic             match;

    assign match      = (x_in == match_val);
    assign eff_thresh = (thresh == '0) ? CNT_W'(1) : thresh;
    assign run_inc    = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);

    always_comb begin
        state_nx = state;
        run_nx   = run_cnt;
        det_nx   = det_cnt;
        pulse_nx = 1'b0;
        if (en) begin
            if (!match) begin
                state_nx = IDLE;
                run_nx   = '0;
            end else begin
                run_nx = run_inc;
                // Once in HIT only a mismatch leaves, whatever thresh does.
                if (state == HIT) begin
                    state_nx = HIT;
                end else if (run_inc >= eff_thresh) begin
                    state_nx = HIT;
                    pulse_nx = 1'b1;
                    if (det_cnt != '1) begin
                        det_nx = det_cnt + DET_W'(1);
                    end
                end else begin
                    state_nx = COUNT;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            run_cnt <= '0;
            det_cnt <= '0;
            y_pulse <= 1'b0;
            y_out   <= 1'b0;
        end else begin
            state   <= state_nx;
            run_cnt <= run_nx;
            det_cnt <= det_nx;
            y_pulse <= pulse_nx;
            y_out   <= (state_nx == HIT);
        end
    end

`ifdef RUN_LEN_DETECTOR_MAXRUN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            max_run <= '0;
        end else if (run_nx > max_run) begin
            max_run <= run_nx;
        end
    end
`else
    assign max_run = '0;
`endif

endmodule

// File: doc/run_len_detector.md
# run_len_detector

Parametrised Moore run-length detector: counts consecutive input samples equal to a programmable polarity and asserts its output once the run reaches a runtime threshold. It also counts detection events and, optionally, records the longest run seen. It is the general replacement for fixed "three-ones-in-a-row" sequence detectors in the lab FSM set. With `match_val=1` and `thresh=3` it reproduces that behaviour exactly.

## Interface
- `CNT_W`, default 4: width of the run counter and threshold; run saturates at 2^CNT_W−1.
- `DET_W`, default 8: width of the detection-event counter.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample enable; 0 freezes all state.
- `x_in`  in  1  serial input sample.
- `match_val`  in  1  polarity counted (1 = runs of ones, 0 = runs of zeros).
- `thresh`  in  CNT_W  run length required for a hit; 0 is treated as 1.
- `y_out`  out  1  level, high while in HIT.
- `y_pulse`  out  1  one-cycle pulse on each entry into HIT.
- `run_cnt`  out  CNT_W  current run length, saturating.
- `det_cnt`  out  DET_W  number of HIT entries, saturating.
- `max_run`  out  CNT_W  longest run since reset (see Configuration).

## Operation
- States: IDLE (run_cnt=0), COUNT (run below threshold), HIT. Encoding is free; all outputs are registered.
- Match: `m = (x_in == match_val)`. Effective threshold: `t = (thresh==0) ? 1 : thresh`.
- On a clock edge with en=1:
  - m=0 → run_cnt←0, state←IDLE, from any state.
  - m=1 → r = run_cnt+1, saturating at all-ones. run_cnt←r. State←HIT if r ≥ t, else COUNT.
  - HIT with m=1 stays HIT, even if `thresh` is raised above run_cnt. Only a mismatch leaves HIT.
- `y_out` = (state==HIT).
- `y_pulse` is 1 for exactly the cycle following a non-HIT→HIT transition, and 0 otherwise.
- `det_cnt` increments on each non-HIT→HIT transition and saturates at 2^DET_W−1 without wrapping.
- en=0: state, run_cnt, det_cnt and max_run hold; y_pulse←0; y_out holds.
- `thresh` and `match_val` are sampled every enabled edge. A mid-run change applies from that edge onward; run_cnt is not cleared.
- Saturated run with continued matches: run_cnt stays all-ones and the state stays HIT.
- A threshold above 2^CNT_W−1 is not representable, so every threshold is reachable.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, y_out=0, y_pulse=0, run_cnt=0, det_cnt=0, max_run=0. Reset asserted mid-run clears everything immediately. The first enabled edge after release evaluates from IDLE.
- Latency: the t-th consecutive match, sampled at edge k, makes y_out=1 and y_pulse=1 valid immediately after edge k.
- The first mismatch, sampled at edge j, makes y_out=0 and run_cnt=0 after edge j.
- No combinational path from inputs to outputs.

## Configuration
- `RUN_LEN_DETECTOR_MAXRUN_EN` defined:
  - `max_run` is a register updated on each enabled edge as max(max_run, new run_cnt).
  - It holds when en=0 and is cleared only by reset.
- Undefined: `max_run` is tied to 0 and no register is synthesised. All other behaviour is identical.

## Test plan
- Baseline (defaults, match_val=1, thresh=3):
  - Stimulus x_in = 1,1,0,1,1,1,1,0.
  - Required: y_out = 0,0,0,0,0,1,1,0; y_pulse high only after the 6th edge; det_cnt=1; run_cnt sequence 1,2,0,1,2,3,4,0.
- Zero polarity, thresh=0:
  - Stimulus match_val=0, x_in = 1,0,1,0,0.
  - Required: hits after edges 2 and 4; det_cnt=2; y_pulse on both hits.
- Enable gating:
  - Stimulus thresh=3, x_in=1 held, en = 1,1,0,0,1.
  - Required: run_cnt = 1,2,2,2,3; y_out rises only after the 5th edge; y_pulse=0 during en=0.
- Saturation (CNT_W=4, DET_W=2):
  - Stimulus 20 consecutive ones with thresh=15.
  - Required: run_cnt sticks at 15 and y_out stays 1.
  - Then 5 pulses of the pattern 1×15,0: det_cnt stops at 3.
- Async reset mid-run:
  - Stimulus: assert reset=0 between edges while in HIT with det_cnt=2.
  - Required: all outputs 0 immediately, before the next clock edge.
- Threshold change in HIT:
  - Stimulus: with run_cnt=3 in HIT, raise thresh to 8 and keep ones.
  - Required: y_out stays 1 and no new y_pulse.
  - With `RUN_LEN_DETECTOR_MAXRUN_EN`, a subsequent run of 5 followed by a run of 2 leaves max_run=5.
